// File: rtl/mem_req_ctrl_pkg.sv
// Shared definitions for the MEM-stage bus request controller:
// FSM encoding, access size codes and the alignment rule.
package mem_req_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Size code 3 is never legal, whatever the address.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~addr_lo[0];
      SZ_WORD: is_aligned = (addr_lo == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_ctrl_strb_gen.sv
// Byte-lane strobes and store-data replication for one access.
// Purely combinational; the caller decides whether the strobes are used.
module mem_strb_gen
  import mem_req_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_out
);

  always_comb begin
    wstrb     = 4'b0000;
    wdata_out = wdata;
    case (size)
      SZ_BYTE: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_out = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        wstrb     = 4'b0011 << addr_lo;
        wdata_out = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        wstrb     = 4'b1111;
        wdata_out = wdata;
      end
      default: begin
        wstrb     = 4'b0000;
        wdata_out = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// MEM-stage load/store controller: turns a held pipeline request into a single
// outstanding bus transaction, stalling the pipeline until it completes.
//
// Bus handshake: bus_req is held with stable fields until bus_addr_ok is seen
// (address phase accepted); bus_data_ok then marks completion of that same
// transaction, possibly in the same cycle as bus_addr_ok. Only one transaction
// is ever outstanding, so no IDs are needed.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stallreq,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              addr_err,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        dbg_state
);

  state_t            state, state_next;
  logic              we_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              discard_q;
  logic [DATA_W-1:0] rdata_q;

  logic              aligned;
  logic              accept;
  logic              capture;
  logic [3:0]        strb_raw;
  logic [DATA_W-1:0] wdata_rep;

  assign aligned = is_aligned(req_size, req_addr[1:0]);
  assign accept  = (state == ST_IDLE) && req_valid && aligned && !flush && !rst;

  // A discarded (flushed) transaction still drains the bus but never updates rdata.
  assign capture = bus_data_ok && !we_q && !flush && !discard_q &&
                   (((state == ST_ADDR) && bus_addr_ok) || (state == ST_DATA));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_ADDR;
      ST_ADDR: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) state_next = flush ? ST_IDLE : ST_DONE;
          else             state_next = ST_DATA;
        end else if (flush) begin
          state_next = ST_IDLE;
        end
      end
      ST_DATA: if (bus_data_ok) state_next = (flush || discard_q) ? ST_IDLE : ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    stallreq    = 1'b0;
    bus_req     = 1'b0;
    rdata_valid = 1'b0;
    addr_err    = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          stallreq = accept;
          addr_err = req_valid && !flush && !aligned;
        end
        ST_ADDR: begin
          stallreq = 1'b1;
          bus_req  = 1'b1;
        end
        ST_DATA: stallreq = 1'b1;
        ST_DONE: rdata_valid = !we_q;
        default: stallreq = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) discard_q <= 1'b0;
    else     discard_q <= (state_next == ST_DATA) && (discard_q || flush);
  end

  always_ff @(posedge clk) begin
    if (rst)          rdata_q <= '0;
    else if (capture) rdata_q <= bus_rdata;
  end

  mem_strb_gen u_strb_gen (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .wstrb     (strb_raw),
    .wdata_out (wdata_rep)
  );

  assign rdata     = rdata_q;
  assign bus_wr    = we_q;
  assign bus_size  = size_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_rep;
  assign bus_wstrb = (bus_req && we_q) ? strb_raw : 4'b0000;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: loads, stores, misaligned requests,
// flushes in each phase and reset mid-transaction.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stallreq;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        addr_err;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2, S_DONE = 2'd3;

  mem_req_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stallreq    (stallreq),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .addr_err    (addr_err),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
    bus_addr_ok = aok;
    bus_data_ok = dok;
    bus_rdata   = rd;
  endtask

  task automatic quiet_outputs(input string tag);
    chk({tag, "_stall"}, {31'd0, stallreq}, 32'd0);
    chk({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, rdata_valid}, 32'd0);
    chk({tag, "_addr_err"}, {31'd0, addr_err}, 32'd0);
    chk({tag, "_wstrb"}, {28'd0, bus_wstrb}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_size = 2'd0; req_addr = '0; req_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

    // Reset state
    tick(); tick();
    quiet_outputs("rst");
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    rst = 1'b0;
    tick();

    // Word load 0x100, addr_ok on second ADDR cycle, data_ok one cycle later
    issue(1'b0, 2'd2, 32'h100, 32'h0); settle();
    chk("ld_accept_stall", {31'd0, stallreq}, 32'd1);
    chk("ld_accept_bus_req", {31'd0, bus_req}, 32'd0);
    tick();
    chk("ld_addr1_state", {30'd0, dbg_state}, {30'd0, S_ADDR});
    chk("ld_addr1_bus_req", {31'd0, bus_req}, 32'd1);
    chk("ld_addr1_stall", {31'd0, stallreq}, 32'd1);
    chk("ld_bus_addr", bus_addr, 32'h100);
    chk("ld_bus_size", {30'd0, bus_size}, 32'd2);
    chk("ld_bus_wr", {31'd0, bus_wr}, 32'd0);
    chk("ld_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    tick();
    bus(1'b1, 1'b0, 32'h0); settle();
    chk("ld_addr2_bus_req", {31'd0, bus_req}, 32'd1);
    chk("ld_addr2_stall", {31'd0, stallreq}, 32'd1);
    tick();
    bus(1'b0, 1'b1, 32'hDEADBEEF); settle();
    chk("ld_data_state", {30'd0, dbg_state}, {30'd0, S_DATA});
    chk("ld_data_bus_req", {31'd0, bus_req}, 32'd0);
    chk("ld_data_stall", {31'd0, stallreq}, 32'd1);
    tick();
    bus(1'b0, 1'b0, 32'h0); req_valid = 1'b0; settle();
    chk("ld_done_stall", {31'd0, stallreq}, 32'd0);
    chk("ld_done_rvalid", {31'd0, rdata_valid}, 32'd1);
    chk("ld_done_rdata", rdata, 32'hDEADBEEF);
    tick();
    chk("ld_idle_rvalid", {31'd0, rdata_valid}, 32'd0);
    chk("ld_idle_rdata_hold", rdata, 32'hDEADBEEF);
    chk("ld_idle_state", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // Byte store 0x103 0xA5, addr_ok and data_ok together; req_valid held in DONE
    issue(1'b1, 2'd0, 32'h103, 32'h000000A5); settle();
    chk("sb_accept_stall", {31'd0, stallreq}, 32'd1);
    tick();
    bus(1'b1, 1'b1, 32'h55555555); settle();
    chk("sb_wstrb", {28'd0, bus_wstrb}, 32'h8);
    chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
    chk("sb_bus_wr", {31'd0, bus_wr}, 32'd1);
    chk("sb_bus_size", {30'd0, bus_size}, 32'd0);
    tick();
    bus(1'b0, 1'b0, 32'h0); settle();
    chk("sb_done_state", {30'd0, dbg_state}, {30'd0, S_DONE});
    chk("sb_done_rvalid", {31'd0, rdata_valid}, 32'd0);
    chk("sb_done_stall", {31'd0, stallreq}, 32'd0);
    chk("sb_rdata_untouched", rdata, 32'hDEADBEEF);
    tick();
    req_valid = 1'b0; settle();
    chk("sb_no_accept_in_done", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // Half store 0x102 0x1234, data_ok a cycle after addr_ok
    issue(1'b1, 2'd1, 32'h102, 32'hFFFF1234); settle();
    tick();
    bus(1'b1, 1'b0, 32'h0); settle();
    chk("sh_wstrb", {28'd0, bus_wstrb}, 32'hC);
    chk("sh_wdata", bus_wdata, 32'h12341234);
    tick();
    bus(1'b0, 1'b1, 32'h0); settle();
    chk("sh_data_wstrb", {28'd0, bus_wstrb}, 32'h0);
    tick();
    bus(1'b0, 1'b0, 32'h0); req_valid = 1'b0; settle();
    chk("sh_done_rvalid", {31'd0, rdata_valid}, 32'd0);
    tick();

    // Misaligned and illegal requests
    issue(1'b0, 2'd1, 32'h101, 32'h0); settle();
    chk("mis_half_err", {31'd0, addr_err}, 32'd1);
    chk("mis_half_stall", {31'd0, stallreq}, 32'd0);
    chk("mis_half_bus_req", {31'd0, bus_req}, 32'd0);
    tick();
    req_valid = 1'b0; settle();
    chk("mis_half_err_off", {31'd0, addr_err}, 32'd0);
    chk("mis_half_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("mis_half_bus_req2", {31'd0, bus_req}, 32'd0);
    issue(1'b1, 2'd2, 32'h102, 32'h0); settle();
    chk("mis_word_err", {31'd0, addr_err}, 32'd1);
    issue(1'b0, 2'd3, 32'h100, 32'h0); settle();
    chk("size3_err", {31'd0, addr_err}, 32'd1);
    chk("size3_stall", {31'd0, stallreq}, 32'd0);
    tick();
    req_valid = 1'b0; settle();
    chk("size3_state", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // Flush in IDLE blocks acceptance
    issue(1'b0, 2'd2, 32'h180, 32'h0); flush = 1'b1; settle();
    chk("flush_idle_stall", {31'd0, stallreq}, 32'd0);
    tick();
    flush = 1'b0; req_valid = 1'b0; settle();
    chk("flush_idle_state", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // Flush in ADDR before addr_ok
    issue(1'b0, 2'd2, 32'h200, 32'h0); settle();
    tick();
    flush = 1'b1; settle();
    chk("flush_addr_bus_req", {31'd0, bus_req}, 32'd1);
    tick();
    flush = 1'b0; req_valid = 1'b0; settle();
    chk("flush_addr_bus_req_drop", {31'd0, bus_req}, 32'd0);
    chk("flush_addr_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("flush_addr_rvalid", {31'd0, rdata_valid}, 32'd0);
    chk("flush_addr_stall", {31'd0, stallreq}, 32'd0);

    // Flush in DATA: wait for data_ok, no pulse, rdata unchanged
    issue(1'b0, 2'd2, 32'h300, 32'h0); settle();
    tick();
    bus(1'b1, 1'b0, 32'h0); settle();
    tick();
    bus(1'b0, 1'b0, 32'h0); flush = 1'b1; settle();
    chk("flush_data_stall", {31'd0, stallreq}, 32'd1);
    tick();
    flush = 1'b0; req_valid = 1'b0; settle();
    chk("flush_data_wait_state", {30'd0, dbg_state}, {30'd0, S_DATA});
    chk("flush_data_wait_stall", {31'd0, stallreq}, 32'd1);
    bus(1'b0, 1'b1, 32'h11111111); settle();
    tick();
    bus(1'b0, 1'b0, 32'h0); settle();
    chk("flush_data_end_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("flush_data_rvalid", {31'd0, rdata_valid}, 32'd0);
    chk("flush_data_rdata", rdata, 32'hDEADBEEF);

    // Flush in ADDR together with addr_ok: discarded, drains through DATA
    issue(1'b0, 2'd2, 32'h340, 32'h0); settle();
    tick();
    bus(1'b1, 1'b0, 32'h0); flush = 1'b1; settle();
    tick();
    bus(1'b0, 1'b1, 32'h22222222); flush = 1'b0; req_valid = 1'b0; settle();
    chk("flush_aok_stall", {31'd0, stallreq}, 32'd1);
    tick();
    bus(1'b0, 1'b0, 32'h0); settle();
    chk("flush_aok_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    chk("flush_aok_rvalid", {31'd0, rdata_valid}, 32'd0);
    chk("flush_aok_rdata", rdata, 32'hDEADBEEF);

    // Reset in DATA, then a late data_ok
    issue(1'b1, 2'd2, 32'h400, 32'h87654321); settle();
    tick();
    bus(1'b1, 1'b0, 32'h0); settle();
    tick();
    bus(1'b0, 1'b0, 32'h0); rst = 1'b1; settle();
    quiet_outputs("rst_mid");
    tick();
    rst = 1'b0; req_valid = 1'b0; bus(1'b0, 1'b1, 32'h33333333); settle();
    chk("rst_mid_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    quiet_outputs("late_dok");
    chk("late_dok_rdata", rdata, 32'h0);
    tick();
    bus(1'b0, 1'b0, 32'h0); settle();
    chk("late_dok_rdata2", rdata, 32'h0);
    chk("late_dok_state", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // Next request completes normally
    issue(1'b0, 2'd2, 32'h500, 32'h0); settle();
    chk("post_rst_accept", {31'd0, stallreq}, 32'd1);
    tick();
    chk("post_rst_bus_addr", bus_addr, 32'h500);
    bus(1'b1, 1'b1, 32'hCAFEF00D); settle();
    tick();
    bus(1'b0, 1'b0, 32'h0); req_valid = 1'b0; settle();
    chk("post_rst_rvalid", {31'd0, rdata_valid}, 32'd1);
    chk("post_rst_rdata", rdata, 32'hCAFEF00D);
    tick();
    chk("post_rst_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
